// File: rtl/lfsr_checker.sv
// Receive-side checker for the XNOR-feedback LFSR pattern generator: self-syncs to
// the serial stream, then flywheels locally and counts bit errors while locked.
module lfsr_checker #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned TAP      = 7,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_sr;        // bit 0 is the newest bit (stage 1)
  logic [FILL_W-1:0]    r_fill_cnt;
  logic [MATCH_W-1:0]   r_match_cnt;
  logic [MISS_W-1:0]    r_miss_cnt;
  logic                 r_locked;
  logic                 r_err_pulse;
  logic [ERR_W-1:0]     r_err_count;

  logic w_expected;
  logic w_match;
  logic w_lockup;
  logic w_load;
  logic w_err_sat;

  assign w_expected = ~(r_sr[TAP-1] ^ r_sr[WIDTH-1]);
  assign w_match    = (din == w_expected);
  assign w_lockup   = &r_sr;
  // Flywheel on the local sequence once locked so a line error is counted once.
  assign w_load     = (r_state == ST_LOCKED) ? w_expected : din;
  assign w_err_sat  = &r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_sr        <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (clear_cnt) r_err_count <= '0;
      if (din_valid) begin
        r_sr <= {r_sr[WIDTH-2:0], w_load};
        case (r_state)
          ST_FILL: begin
            if (r_fill_cnt == FILL_W'(WIDTH - 1)) begin
              r_state     <= ST_HUNT;
              r_fill_cnt  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            end
          end
          ST_HUNT: begin
            // An all-ones register is the XNOR lockup state; never accept it.
            if (w_lockup || !w_match) begin
              r_match_cnt <= '0;
            end else if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_match_cnt <= '0;
              r_miss_cnt  <= '0;
            end else begin
              r_match_cnt <= r_match_cnt + MATCH_W'(1);
            end
          end
          ST_LOCKED: begin
            if (!w_match) begin
              r_err_pulse <= 1'b1;
              if (!clear_cnt && !w_err_sat) r_err_count <= r_err_count + ERR_W'(1);
              if (r_miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
                r_state    <= ST_FILL;
                r_locked   <= 1'b0;
                r_fill_cnt <= '0;
                r_miss_cnt <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + MISS_W'(1);
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end
          default: r_state <= ST_FILL;
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
